// File: rtl/seq_detect_pkg.sv
// Shared types, default widths and helpers for the serial pattern detection controller.
package seq_detect_pkg;

    localparam int DEF_PAT_W = 8;
    localparam int DEF_CNT_W = 8;
    localparam int DEF_TMO_W = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARM,
        ST_RUN,
        ST_DONE,
        ST_ERR
    } state_e;

    // A zero length still means a one-bit pattern; lengths past the register width are capped.
    function automatic int clamp_len(input int len, input int max_len);
        int r;
        r = len;
        if (len < 1) begin
            r = 1;
        end else if (len > max_len) begin
            r = max_len;
        end
        return r;
    endfunction

endpackage

// File: rtl/seq_detect_ctrl_core.sv
// Serial match datapath: shift register, fill counter and length-masked comparison.
// full and match are combinational and describe the window that includes the current bit.
module seq_match_core
    import seq_detect_pkg::*;
#(
    parameter int PAT_W = DEF_PAT_W,
    parameter int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             vld,
    input  logic             data,
    input  logic [LEN_W-1:0] len,
    input  logic [PAT_W-1:0] pattern,
    output logic             full,
    output logic             match
);

    logic [PAT_W-1:0] sr_q, sr_d;
    logic [PAT_W-1:0] sr_shift;
    logic [PAT_W-1:0] len_mask;
    logic [LEN_W-1:0] fill_q, fill_d;

    // Next shift-register image, window mask and fill tracking for the current bit.
    always_comb begin
        sr_shift = {sr_q[PAT_W-2:0], data};
        for (int i = 0; i < PAT_W; i++) begin
            len_mask[i] = (LEN_W'(i) < len);
        end
        full  = (fill_q >= len) || (vld && ((fill_q + LEN_W'(1)) >= len));
        match = vld && full && (((sr_shift ^ pattern) & len_mask) == '0);

        sr_d   = sr_q;
        fill_d = fill_q;
        if (clr) begin
            sr_d   = '0;
            fill_d = '0;
        end else if (vld) begin
            sr_d = sr_shift;
            if (fill_q < LEN_W'(PAT_W)) begin
                fill_d = fill_q + LEN_W'(1);
            end
        end
    end

    // Shift register and fill count storage.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sr_q   <= '0;
            fill_q <= '0;
        end else begin
            sr_q   <= sr_d;
            fill_q <= fill_d;
        end
    end

endmodule

// File: rtl/seq_detect_ctrl.sv
// Programmable serial pattern detection controller: config latch, run FSM,
// match counter and no-match timeout around the seq_match_core datapath.
module seq_detect_ctrl
    import seq_detect_pkg::*;
#(
    parameter  int PAT_W = DEF_PAT_W,
    parameter  int CNT_W = DEF_CNT_W,
    parameter  int TMO_W = DEF_TMO_W,
    localparam int LEN_W = $clog2(PAT_W + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_wr,
    input  logic [PAT_W-1:0] cfg_pattern,
    input  logic [LEN_W-1:0] cfg_len,
    input  logic [CNT_W-1:0] cfg_target,
    input  logic [TMO_W-1:0] cfg_timeout,
    input  logic             start,
    input  logic             abort,
    input  logic             data_vld,
    input  logic             data,
    output logic             busy,
    output logic             flag,
    output logic [CNT_W-1:0] match_cnt,
    output logic             done,
    output logic             timeout_err
);

    state_e           state_q, state_d;
    logic [PAT_W-1:0] pattern_q, pattern_d;
    logic [LEN_W-1:0] len_q, len_d;
    logic [CNT_W-1:0] target_q, target_d;
    logic [TMO_W-1:0] tlim_q, tlim_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic             busy_q, busy_d;
    logic             flag_q, flag_d;
    logic             done_q, done_d;
    logic             err_q, err_d;

    logic             busy_state;
    logic             core_vld;
    logic             core_clr;
    logic             core_full;
    logic             core_match;

    seq_match_core #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_core (
        .clk     (clk),
        .rst     (rst),
        .clr     (core_clr),
        .vld     (core_vld),
        .data    (data),
        .len     (len_q),
        .pattern (pattern_q),
        .full    (core_full),
        .match   (core_match)
    );

    // Run sequencing: config latch when idle, start/abort handling, match counting and timeout.
    always_comb begin
        busy_state = (state_q == ST_ARM) || (state_q == ST_RUN);
        core_vld   = busy_state && data_vld && !abort;
        core_clr   = start && !busy_state && !abort;
        cnt_inc    = (cnt_q == {CNT_W{1'b1}}) ? cnt_q : cnt_q + CNT_W'(1);
        tmo_inc    = (tmo_q == {TMO_W{1'b1}}) ? tmo_q : tmo_q + TMO_W'(1);

        state_d   = state_q;
        pattern_d = pattern_q;
        len_d     = len_q;
        target_d  = target_q;
        tlim_d    = tlim_q;
        cnt_d     = cnt_q;
        tmo_d     = tmo_q;
        flag_d    = 1'b0;
        done_d    = done_q;
        err_d     = err_q;

        if (cfg_wr && !busy_state) begin
            pattern_d = cfg_pattern;
            len_d     = LEN_W'(clamp_len(int'(cfg_len), PAT_W));
            target_d  = cfg_target;
            tlim_d    = cfg_timeout;
        end

        if (abort) begin
            state_d = ST_IDLE;
            done_d  = 1'b0;
            err_d   = 1'b0;
        end else begin
            case (state_q)
                ST_IDLE, ST_DONE, ST_ERR: begin
                    if (start) begin
                        state_d = ST_ARM;
                        cnt_d   = '0;
                        tmo_d   = '0;
                        done_d  = 1'b0;
                        err_d   = 1'b0;
                    end
                end
                ST_ARM, ST_RUN: begin
                    if (core_match) begin
                        flag_d = 1'b1;
                        cnt_d  = cnt_inc;
                        tmo_d  = '0;
                        if ((target_q != '0) && (cnt_inc == target_q)) begin
                            state_d = ST_DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d = ST_RUN;
                        end
                    end else begin
                        tmo_d = tmo_inc;
                        if ((tlim_q != '0) && (tmo_inc == tlim_q)) begin
                            state_d = ST_ERR;
                            err_d   = 1'b1;
                        end else if (core_full) begin
                            state_d = ST_RUN;
                        end
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end

        busy_d = (state_d == ST_ARM) || (state_d == ST_RUN);
    end

    // State, latched configuration, counters and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            pattern_q <= '0;
            len_q     <= LEN_W'(PAT_W);
            target_q  <= '0;
            tlim_q    <= '0;
            cnt_q     <= '0;
            tmo_q     <= '0;
            busy_q    <= 1'b0;
            flag_q    <= 1'b0;
            done_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            pattern_q <= pattern_d;
            len_q     <= len_d;
            target_q  <= target_d;
            tlim_q    <= tlim_d;
            cnt_q     <= cnt_d;
            tmo_q     <= tmo_d;
            busy_q    <= busy_d;
            flag_q    <= flag_d;
            done_q    <= done_d;
            err_q     <= err_d;
        end
    end

    assign busy        = busy_q;
    assign flag        = flag_q;
    assign match_cnt   = cnt_q;
    assign done        = done_q;
    assign timeout_err = err_q;

endmodule
